game_cmd_sequencer: RTL
=======================

GAME_CMD_SEQUENCER -- requirements
Module: game_cmd_sequencer

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, per-player command buffer entries; TURN_TIMEOUT, default 255, idle cycles before a turn is forfeited.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- p1_cmd_valid / p2_cmd_valid  in  1  player command offered.
- p1_cmd_kind / p2_cmd_kind  in  1  0 = buy, 1 = play.
- p1_cmd_code / p2_cmd_code  in  3  action code 0..4: kick, punch, left, right, wait.
- p1_cmd_ready / p2_cmd_ready  out  1  buffer not full; the command is accepted when valid and ready are both high.
- p1_fight_req / p2_fight_req  in  1  one-cycle "ready to fight" pulse.
- phase  in  1  game phase: 0 = play, 1 = shop.
- winner  in  2  game winner code.
- err_no_inventory, err_wrong_distance  in  1  game error flags, registered by the game.
- turn  out  1  0 = P1 active, 1 = P2 active.
- play_valid  out  1  play strobe.
- play_action  out  3  play action code.
- buy_valid_p1, buy_valid_p2  out  1  buy strobes.
- buy_code_p1, buy_code_p2  out  3  buy codes.
- start_round  out  1  round start strobe.
- turn_skipped  out  1  one-cycle pulse on timeout forfeit.
- drop_p1, drop_p2  out  1  one-cycle pulse when a command is discarded.
- err_count  out  8  saturating count of errored plays.
- round_count  out  8  saturating count of completed rounds.
- last_winner  out  2  winner of the most recent round.

Function
REQ-003 SHALL buffer each player's commands in an independent FIFO; ready SHALL be low exactly when that FIFO holds FIFO_DEPTH entries; a push attempted while full SHALL be ignored.
REQ-004 All strobe outputs SHALL be single-cycle and registered, driven from the FSM states S_SHOP, S_START, S_ISSUE and S_WAIT.
REQ-005 In S_SHOP, a buy-kind command at a player's FIFO head SHALL be popped and issued the next cycle as that player's buy_valid with its buy_code; at most one buy per player per cycle; both players' buys MAY be issued in the same cycle.
REQ-006 In S_SHOP, a play-kind command at a FIFO head SHALL be held, not popped.
REQ-007 Each fight_req pulse SHALL set a sticky flag for that player.
REQ-008 When both fight flags are set, neither FIFO head is buy-kind, and no buy strobe is asserted this cycle, the block SHALL pulse start_round, clear both flags, and enter S_START.
REQ-009 In S_START, when phase==0 the block SHALL set turn=0 and enter S_ISSUE; while phase stays 1, start_round SHALL NOT be re-pulsed.
REQ-010 In S_ISSUE:
- A play-kind command at the active player's FIFO head SHALL be popped and issued as play_valid=1 with play_action=code and turn held; the FSM then enters S_WAIT.
- A buy-kind command at the active player's head SHALL be popped, discarded, and pulse drop_pX.
- The inactive player's FIFO SHALL NOT be popped.
REQ-011 In S_WAIT (exactly one cycle after play_valid), the block SHALL sample err_no_inventory|err_wrong_distance and increment err_count (saturating at 255) if either is set, then toggle turn and return to S_ISSUE.
REQ-012 A 9-bit idle counter SHALL count cycles spent in S_ISSUE without an issue and reset on every issue or turn change; on reaching TURN_TIMEOUT the block SHALL pulse turn_skipped and toggle turn.
REQ-013 In S_ISSUE or S_WAIT, phase==1 observed with winner!=0 SHALL:
- latch last_winner;
- increment round_count (saturating);
- flush both FIFOs;
- clear both fight flags;
- set turn=0;
- enter S_SHOP.
REQ-014 Phase==1 observed with winner==0 SHALL do the same except round_count and last_winner stay unchanged.
REQ-015 A push and a pop on the same FIFO in the same cycle SHALL both take effect; a push during a flush cycle SHALL be discarded.

Reset
REQ-016 While rst_n==0 at a clk edge, the block SHALL:
- enter S_SHOP;
- empty both FIFOs;
- clear fight flags, the idle counter, err_count, round_count and last_winner;
- drive turn=0 and all strobes and drop pulses to 0, with play_action, buy_code_p1 and buy_code_p2 at 0.
REQ-017 Reset asserted mid-operation SHALL abandon any pending strobe; no strobe SHALL be asserted in the first cycle after reset release.

Structure
REQ-018 Action codes, phase encodings, command-kind encoding and FSM state encodings SHALL live in a shared package game_pkg.
REQ-019 Each FIFO SHALL be an instance of one sub-module cmd_fifo (parameterised depth, 4-bit payload, push/pop/flush, full/empty).

Verification
REQ-020 Buy path: in shop, P1 pushes buy 1 and buy 3 -> buy_valid_p1 pulses on two consecutive cycles with codes 1 then 3.
REQ-021 Start gating: fight_req from P1 only -> no start_round; P2 fight_req 5 cycles later -> exactly one start_round pulse.
REQ-022 Alternation: in play, P1 queue kick, P2 queue punch -> play_valid with turn=0, action 0; two cycles later turn=1, action 1.
REQ-023 Error count: err_wrong_distance=1 in the S_WAIT cycle -> err_count increments from 0 to 1.
REQ-024 Timeout: P1 queue empty for 255 cycles in S_ISSUE -> turn_skipped pulses and turn goes to 1.
REQ-025 Round end: phase goes to 1 with winner=2'b10 -> last_winner=2'b10, round_count=1, FIFOs empty, turn=0; a full FIFO holds ready low until a pop.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game command sequencer:
// action codes, command kinds, game phases and FSM states.
package game_pkg;

   localparam int CMD_W = 4;

   typedef enum logic [2:0] {
      ACT_KICK  = 3'd0,
      ACT_PUNCH = 3'd1,
      ACT_LEFT  = 3'd2,
      ACT_RIGHT = 3'd3,
      ACT_WAIT  = 3'd4
   } action_e;

   typedef enum logic {
      KIND_BUY  = 1'b0,
      KIND_PLAY = 1'b1
   } cmd_kind_e;

   typedef enum logic {
      PHASE_PLAY = 1'b0,
      PHASE_SHOP = 1'b1
   } phase_e;

   typedef enum logic [1:0] {
      S_SHOP  = 2'd0,
      S_START = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_e;

   typedef struct packed {
      cmd_kind_e kind;
      action_e   code;
   } cmd_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO with synchronous flush.
// Ports: push/din, pop, flush in; dout (head), full, empty out.
module cmd_fifo
   import game_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [CMD_W-1:0] din,
   input  logic             pop,
   input  logic             flush,
   output logic [CMD_W-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // A flush wins over any push or pop in the same cycle.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/game_cmd_sequencer.sv
// Two-player command sequencer: buffers commands, issues buys in
// the shop phase and alternating plays in the fight phase.
// Ports: per-player cmd valid/kind/code/ready and fight_req;
// game phase/winner/error flags in; registered turn, play/buy
// strobes, start/skip/drop pulses and round statistics out.
module game_cmd_sequencer
   import game_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int TURN_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       p1_cmd_valid,
   input  logic       p2_cmd_valid,
   input  logic       p1_cmd_kind,
   input  logic       p2_cmd_kind,
   input  logic [2:0] p1_cmd_code,
   input  logic [2:0] p2_cmd_code,
   output logic       p1_cmd_ready,
   output logic       p2_cmd_ready,
   input  logic       p1_fight_req,
   input  logic       p2_fight_req,
   input  logic       phase,
   input  logic [1:0] winner,
   input  logic       err_no_inventory,
   input  logic       err_wrong_distance,
   output logic       turn,
   output logic       play_valid,
   output logic [2:0] play_action,
   output logic       buy_valid_p1,
   output logic       buy_valid_p2,
   output logic [2:0] buy_code_p1,
   output logic [2:0] buy_code_p2,
   output logic       start_round,
   output logic       turn_skipped,
   output logic       drop_p1,
   output logic       drop_p2,
   output logic [7:0] err_count,
   output logic [7:0] round_count,
   output logic [1:0] last_winner
);

   state_e state_q, state_d;

   logic       flag1_q, flag1_d;
   logic       flag2_q, flag2_d;
   logic [8:0] idle_q, idle_d, idle_inc;

   logic       turn_d;
   logic       play_valid_d;
   logic [2:0] play_action_d;
   logic       buy_valid_p1_d, buy_valid_p2_d;
   logic [2:0] buy_code_p1_d, buy_code_p2_d;
   logic       start_round_d;
   logic       turn_skipped_d;
   logic       drop_p1_d, drop_p2_d;
   logic [7:0] err_count_d, round_count_d;
   logic [1:0] last_winner_d;

   logic [CMD_W-1:0] dout1, dout2;
   cmd_t       head1, head2, act_head;
   logic       empty1, empty2, full1, full2;
   logic       push1, push2, pop1, pop2, flush;
   logic       head1_buy, head2_buy;
   logic       act_empty, round_end, timeout;

   assign p1_cmd_ready = ~full1;
   assign p2_cmd_ready = ~full2;
   assign push1 = p1_cmd_valid & p1_cmd_ready;
   assign push2 = p2_cmd_valid & p2_cmd_ready;

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_p1 (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push1),
      .din   ({p1_cmd_kind, p1_cmd_code}),
      .pop   (pop1),
      .flush (flush),
      .dout  (dout1),
      .full  (full1),
      .empty (empty1)
   );

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_p2 (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push2),
      .din   ({p2_cmd_kind, p2_cmd_code}),
      .pop   (pop2),
      .flush (flush),
      .dout  (dout2),
      .full  (full2),
      .empty (empty2)
   );

   assign head1     = cmd_t'(dout1);
   assign head2     = cmd_t'(dout2);
   assign head1_buy = !empty1 && (head1.kind == KIND_BUY);
   assign head2_buy = !empty2 && (head2.kind == KIND_BUY);
   assign act_head  = turn ? head2 : head1;
   assign act_empty = turn ? empty2 : empty1;
   assign round_end = (phase == PHASE_SHOP);
   assign idle_inc  = idle_q + 9'd1;
   assign timeout   = (32'(idle_inc) >= TURN_TIMEOUT);

   always_comb begin
      state_d        = state_q;
      flag1_d        = flag1_q | p1_fight_req;
      flag2_d        = flag2_q | p2_fight_req;
      idle_d         = idle_q;
      turn_d         = turn;
      play_valid_d   = 1'b0;
      play_action_d  = play_action;
      buy_valid_p1_d = 1'b0;
      buy_valid_p2_d = 1'b0;
      buy_code_p1_d  = buy_code_p1;
      buy_code_p2_d  = buy_code_p2;
      start_round_d  = 1'b0;
      turn_skipped_d = 1'b0;
      drop_p1_d      = 1'b0;
      drop_p2_d      = 1'b0;
      err_count_d    = err_count;
      round_count_d  = round_count;
      last_winner_d  = last_winner;
      pop1           = 1'b0;
      pop2           = 1'b0;
      flush          = 1'b0;

      unique case (state_q)
         S_SHOP: begin
            if (head1_buy) begin
               pop1           = 1'b1;
               buy_valid_p1_d = 1'b1;
               buy_code_p1_d  = head1.code;
            end
            if (head2_buy) begin
               pop2           = 1'b1;
               buy_valid_p2_d = 1'b1;
               buy_code_p2_d  = head2.code;
            end
            // Let outstanding buys drain before the round opens.
            if (flag1_q && flag2_q && !head1_buy && !head2_buy &&
                !buy_valid_p1 && !buy_valid_p2) begin
               start_round_d = 1'b1;
               flag1_d       = 1'b0;
               flag2_d       = 1'b0;
               state_d       = S_START;
            end
         end
         S_START: begin
            if (phase == PHASE_PLAY) begin
               turn_d  = 1'b0;
               idle_d  = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (round_end) begin
               flush   = 1'b1;
               flag1_d = 1'b0;
               flag2_d = 1'b0;
               turn_d  = 1'b0;
               idle_d  = '0;
               state_d = S_SHOP;
               if (winner != 2'b00) begin
                  last_winner_d = winner;
                  round_count_d = sat_inc8(round_count);
               end
            end else if (state_q == S_WAIT) begin
               if (err_no_inventory || err_wrong_distance)
                  err_count_d = sat_inc8(err_count);
               turn_d  = ~turn;
               idle_d  = '0;
               state_d = S_ISSUE;
            end else if (!act_empty && act_head.kind == KIND_PLAY) begin
               pop1          = ~turn;
               pop2          = turn;
               play_valid_d  = 1'b1;
               play_action_d = act_head.code;
               idle_d        = '0;
               state_d       = S_WAIT;
            end else begin
               // Buys are illegal mid-fight: discard them, keep timing.
               if (!act_empty) begin
                  pop1      = ~turn;
                  pop2      = turn;
                  drop_p1_d = ~turn;
                  drop_p2_d = turn;
               end
               if (timeout) begin
                  turn_skipped_d = 1'b1;
                  turn_d         = ~turn;
                  idle_d         = '0;
               end else begin
                  idle_d = idle_inc;
               end
            end
         end
         default: state_d = S_SHOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_SHOP;
         flag1_q      <= 1'b0;
         flag2_q      <= 1'b0;
         idle_q       <= '0;
         turn         <= 1'b0;
         play_valid   <= 1'b0;
         play_action  <= '0;
         buy_valid_p1 <= 1'b0;
         buy_valid_p2 <= 1'b0;
         buy_code_p1  <= '0;
         buy_code_p2  <= '0;
         start_round  <= 1'b0;
         turn_skipped <= 1'b0;
         drop_p1      <= 1'b0;
         drop_p2      <= 1'b0;
         err_count    <= '0;
         round_count  <= '0;
         last_winner  <= '0;
      end else begin
         state_q      <= state_d;
         flag1_q      <= flag1_d;
         flag2_q      <= flag2_d;
         idle_q       <= idle_d;
         turn         <= turn_d;
         play_valid   <= play_valid_d;
         play_action  <= play_action_d;
         buy_valid_p1 <= buy_valid_p1_d;
         buy_valid_p2 <= buy_valid_p2_d;
         buy_code_p1  <= buy_code_p1_d;
         buy_code_p2  <= buy_code_p2_d;
         start_round  <= start_round_d;
         turn_skipped <= turn_skipped_d;
         drop_p1      <= drop_p1_d;
         drop_p2      <= drop_p2_d;
         err_count    <= err_count_d;
         round_count  <= round_count_d;
         last_winner  <= last_winner_d;
      end
   end

endmodule
